// File: rtl/multicycle_control.sv
// multicycle_control
// Control unit for a multicycle load/store/ALU/branch datapath. A Moore FSM
// sequences each instruction through fetch, decode and the class-specific
// execute states, and a 16-bit counter tracks retired instructions.
//
// Ports
//   clk          single clock, all state changes on its rising edge
//   reset        synchronous, active-high
//   opcode[6:0]  instruction[6:0]; only looked at while in DECODE
//   mem_ready    memory finishes the current read/write this cycle
//   pcwrite, pcwritecond, irwrite, iord, memread, memwrite, memtoreg,
//   regwrite, alusrca, pcsource       datapath enables and selects
//   alusrcb[1:0] ALU operand-B select
//   aluop[1:0]   00 add, 01 subtract/compare, 10 funct-decoded
//   state[3:0]   current FSM state (debug)
//   illegal      high while in TRAP
//   instret[15:0] retired-instruction counter, wraps silently
//
// Handshake: mem_ready is a completion strobe. A memory access is issued
// while the FSM sits in FETCH, MEMRD or MEMWR; the FSM holds that state (and
// its memread/memwrite/iord) until the cycle in which mem_ready=1, and only
// that cycle counts as the access completing.
module multicycle_control (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic        mem_ready,
  output logic        pcwrite,
  output logic        pcwritecond,
  output logic        irwrite,
  output logic        iord,
  output logic        memread,
  output logic        memwrite,
  output logic        memtoreg,
  output logic        regwrite,
  output logic        alusrca,
  output logic        pcsource,
  output logic [1:0]  alusrcb,
  output logic [1:0]  aluop,
  output logic [3:0]  state,
  output logic        illegal,
  output logic [15:0] instret
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_TRAP   = 4'd9
  } state_t;

  typedef enum logic [1:0] {
    C_RT  = 2'd0,
    C_LW  = 2'd1,
    C_SW  = 2'd2,
    C_BEQ = 2'd3
  } cls_t;

  localparam logic [6:0] OP_RT  = 7'b0110011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  state_t cur_state, nxt_state;
  cls_t   cls;       // opcode class captured in DECODE, used by MEMADR
  cls_t   dec_cls;
  logic   dec_legal;
  logic   retire;

  // Raw enables before the reset gate.
  logic raw_pcwrite, raw_pcwritecond, raw_irwrite, raw_memwrite, raw_regwrite;

  always_comb begin
    dec_cls   = C_RT;
    dec_legal = 1'b1;
    case (opcode)
      OP_RT:   dec_cls = C_RT;
      OP_LW:   dec_cls = C_LW;
      OP_SW:   dec_cls = C_SW;
      OP_BEQ:  dec_cls = C_BEQ;
      default: dec_legal = 1'b0;
    endcase
  end

  // An instruction retires as it leaves its final state; a store's final
  // state only ends once memory accepts the write.
  assign retire = (cur_state == S_MEMWB) || (cur_state == S_ALUWB) ||
                  (cur_state == S_BRANCH) ||
                  ((cur_state == S_MEMWR) && mem_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state <= S_FETCH;
      cls       <= C_RT;
      instret   <= 16'd0;
    end else begin
      cur_state <= nxt_state;
      if (cur_state == S_DECODE && dec_legal) cls <= dec_cls;
      if (retire) instret <= instret + 16'd1;
    end
  end

  always_comb begin
    nxt_state = S_FETCH;
    case (cur_state)
      S_FETCH:  nxt_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (!dec_legal) nxt_state = S_TRAP;
        else begin
          case (dec_cls)
            C_LW, C_SW: nxt_state = S_MEMADR;
            C_RT:       nxt_state = S_EXEC;
            default:    nxt_state = S_BRANCH;
          endcase
        end
      end
      S_MEMADR: nxt_state = (cls == C_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  nxt_state = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  nxt_state = S_FETCH;
      S_MEMWR:  nxt_state = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   nxt_state = S_ALUWB;
      S_ALUWB:  nxt_state = S_FETCH;
      S_BRANCH: nxt_state = S_FETCH;
      S_TRAP:   nxt_state = S_TRAP;
      default:  nxt_state = S_FETCH;  // unused encodings recover
    endcase
  end

  always_comb begin
    raw_pcwrite     = 1'b0;
    raw_pcwritecond = 1'b0;
    raw_irwrite     = 1'b0;
    raw_memwrite    = 1'b0;
    raw_regwrite    = 1'b0;
    iord            = 1'b0;
    memread         = 1'b0;
    memtoreg        = 1'b0;
    alusrca         = 1'b0;
    pcsource        = 1'b0;
    alusrcb         = 2'b00;
    aluop           = 2'b00;
    illegal         = 1'b0;
    case (cur_state)
      S_FETCH: begin
        memread     = 1'b1;
        alusrcb     = 2'b01;
        // PC and IR only update on the cycle the fetch completes.
        raw_irwrite = mem_ready;
        raw_pcwrite = mem_ready;
      end
      S_DECODE: alusrcb = 2'b11;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWB: begin
        raw_regwrite = 1'b1;
        memtoreg     = 1'b1;
      end
      S_MEMWR: begin
        raw_memwrite = 1'b1;
        iord         = 1'b1;
      end
      S_EXEC: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      S_ALUWB: raw_regwrite = 1'b1;
      S_BRANCH: begin
        alusrca         = 1'b1;
        aluop           = 2'b01;
        raw_pcwritecond = 1'b1;
        pcsource        = 1'b1;
      end
      S_TRAP: illegal = 1'b1;
      default: ;
    endcase
  end

  // Architectural writes are suppressed immediately while reset is held.
  assign pcwrite     = raw_pcwrite     & ~reset;
  assign pcwritecond = raw_pcwritecond & ~reset;
  assign irwrite     = raw_irwrite     & ~reset;
  assign memwrite    = raw_memwrite    & ~reset;
  assign regwrite    = raw_regwrite    & ~reset;

  assign state = cur_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control. Scenario tasks drive one cycle at a time
// through drive(), which pushes the expected {state, outputs} for that cycle
// onto exp_q; a monitor pops and compares each entry mid-cycle. Expected
// state sequences come from the documented instruction traces and expected
// outputs from the documented per-state output table.
module tb_multicycle_control;

  localparam int W = 19;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  opcode;
  logic        mem_ready;
  logic        pcwrite, pcwritecond, irwrite, iord, memread, memwrite;
  logic        memtoreg, regwrite, alusrca, pcsource;
  logic [1:0]  alusrcb, aluop;
  logic [3:0]  state;
  logic        illegal;
  logic [15:0] instret;

  localparam logic [6:0] OP_RT  = 7'b0110011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b0101010;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int passes = 0;
  logic [15:0] exp_instret = 16'd0;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .pcwritecond(pcwritecond), .irwrite(irwrite),
    .iord(iord), .memread(memread), .memwrite(memwrite),
    .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
    .pcsource(pcsource), .alusrcb(alusrcb), .aluop(aluop),
    .state(state), .illegal(illegal), .instret(instret)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // Output table, packed as {pcwrite, pcwritecond, irwrite, iord, memread,
  // memwrite, memtoreg, regwrite, alusrca, pcsource, alusrcb, aluop, illegal}.
  function automatic logic [14:0] exp_outs(input logic [3:0] st,
                                           input logic mr, input logic rst);
    logic pw, pwc, irw, io, mrd, mwr, m2r, rw, asa, psrc, ill;
    logic [1:0] asb, aop;
    {pw, pwc, irw, io, mrd, mwr, m2r, rw, asa, psrc, ill} = '0;
    asb = 2'b00;
    aop = 2'b00;
    case (st)
      4'd0: begin mrd = 1; asb = 2'b01; irw = mr; pw = mr; end
      4'd1: asb = 2'b11;
      4'd2: begin asa = 1; asb = 2'b10; end
      4'd3: begin mrd = 1; io = 1; end
      4'd4: begin rw = 1; m2r = 1; end
      4'd5: begin mwr = 1; io = 1; end
      4'd6: begin asa = 1; aop = 2'b10; end
      4'd7: rw = 1;
      4'd8: begin asa = 1; aop = 2'b01; pwc = 1; psrc = 1; end
      4'd9: ill = 1;
      default: ;
    endcase
    if (rst) begin pw = 0; pwc = 0; irw = 0; mwr = 0; rw = 0; end
    return {pw, pwc, irw, io, mrd, mwr, m2r, rw, asa, psrc, asb, aop, ill};
  endfunction

  function automatic logic [6:0] junk_op();
    return 7'($urandom_range(0, 127));
  endfunction

  // ---------------- driver ----------------
  // One cycle: drive inputs at the falling edge and record what the DUT must
  // show during this cycle.
  task automatic drive(input logic [3:0] st, input logic mr, input logic rst,
                       input logic [6:0] op);
    @(negedge clk);
    mem_ready = mr;
    reset     = rst;
    opcode    = op;
    exp_q.push_back({st, exp_outs(st, mr, rst)});
  endtask

  // ---------------- scoreboard monitor ----------------
  always begin
    logic [W-1:0] exp_v, got_v;
    @(negedge clk);
    #3;
    if (exp_q.size() != 0) begin
      exp_v = exp_q.pop_front();
      got_v = {state, pcwrite, pcwritecond, irwrite, iord, memread, memwrite,
               memtoreg, regwrite, alusrca, pcsource, alusrcb, aluop, illegal};
      checks++;
      if (got_v !== exp_v)
        $display("FAIL scoreboard t=%0t got state=%0d outs=%b expected state=%0d outs=%b",
                 $time, got_v[18:15], got_v[14:0], exp_v[18:15], exp_v[14:0]);
      else passes++;
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; mem_ready = 1'b1; opcode = OP_RT;
    @(posedge clk);
    drive(4'd0, 1'b1, 1'b1, junk_op());
    #4;
    checks++;
    if (instret !== 16'd0 || illegal !== 1'b0)
      $display("FAIL reset_regs instret=%h illegal=%b expected 0000/0", instret, illegal);
    else passes++;
    checks++;
    if (pcwrite !== 1'b0 || irwrite !== 1'b0)
      $display("FAIL reset_gate pcwrite=%b irwrite=%b expected 0/0", pcwrite, irwrite);
    else passes++;
    exp_instret = 16'd0;
  endtask

  task automatic test_rt();
    drive(4'd0, 1'b1, 1'b0, junk_op());
    drive(4'd1, 1'b1, 1'b0, OP_RT);
    drive(4'd6, 1'b1, 1'b0, OP_LW);     // opcode changes outside DECODE ignored
    drive(4'd7, 1'b1, 1'b0, junk_op());
    #4;
    checks++;
    if (regwrite !== 1'b1 || memtoreg !== 1'b0)
      $display("FAIL rt_wb regwrite=%b memtoreg=%b expected 1/0", regwrite, memtoreg);
    else passes++;
    exp_instret++;
    @(posedge clk); #2;
    checks++;
    if (instret !== exp_instret)
      $display("FAIL rt_instret got %h expected %h", instret, exp_instret);
    else passes++;
  endtask

  task automatic test_lw_sw();
    drive(4'd0, 1'b1, 1'b0, junk_op());
    drive(4'd1, 1'b1, 1'b0, OP_LW);
    drive(4'd2, 1'b1, 1'b0, OP_SW);     // class was latched in DECODE
    drive(4'd3, 1'b1, 1'b0, junk_op());
    drive(4'd4, 1'b1, 1'b0, junk_op());
    #4;
    checks++;
    if (regwrite !== 1'b1 || memtoreg !== 1'b1)
      $display("FAIL lw_wb regwrite=%b memtoreg=%b expected 1/1", regwrite, memtoreg);
    else passes++;
    exp_instret++;
    drive(4'd0, 1'b1, 1'b0, junk_op());
    drive(4'd1, 1'b1, 1'b0, OP_SW);
    drive(4'd2, 1'b1, 1'b0, OP_LW);
    drive(4'd5, 1'b1, 1'b0, junk_op());
    #4;
    checks++;
    if (memwrite !== 1'b1 || iord !== 1'b1)
      $display("FAIL sw_wr memwrite=%b iord=%b expected 1/1", memwrite, iord);
    else passes++;
    exp_instret++;
    @(posedge clk); #2;
    checks++;
    if (instret !== exp_instret)
      $display("FAIL lw_sw_instret got %h expected %h", instret, exp_instret);
    else passes++;
  endtask

  task automatic test_beq();
    drive(4'd0, 1'b1, 1'b0, junk_op());
    drive(4'd1, 1'b1, 1'b0, OP_BEQ);
    drive(4'd8, 1'b1, 1'b0, junk_op());
    #4;
    checks++;
    if (pcwritecond !== 1'b1 || aluop !== 2'b01)
      $display("FAIL beq_br pcwritecond=%b aluop=%b expected 1/01", pcwritecond, aluop);
    else passes++;
    exp_instret++;
    @(posedge clk); #2;
    checks++;
    if (instret !== exp_instret)
      $display("FAIL beq_instret got %h expected %h", instret, exp_instret);
    else passes++;
  endtask

  task automatic test_fetch_stall();
    for (int i = 0; i < 3; i++) drive(4'd0, 1'b0, 1'b0, junk_op());
    #4;
    checks++;
    if (pcwrite !== 1'b0 || irwrite !== 1'b0 || memread !== 1'b1)
      $display("FAIL fetch_stall pcwrite=%b irwrite=%b memread=%b expected 0/0/1",
               pcwrite, irwrite, memread);
    else passes++;
    drive(4'd0, 1'b1, 1'b0, junk_op());
    drive(4'd1, 1'b1, 1'b0, OP_RT);
    drive(4'd6, 1'b1, 1'b0, junk_op());
    drive(4'd7, 1'b1, 1'b0, junk_op());
    exp_instret++;
  endtask

  task automatic test_mem_stall();
    drive(4'd0, 1'b1, 1'b0, junk_op());
    drive(4'd1, 1'b1, 1'b0, OP_LW);
    drive(4'd2, 1'b1, 1'b0, junk_op());
    drive(4'd3, 1'b0, 1'b0, junk_op());
    drive(4'd3, 1'b0, 1'b0, junk_op());
    drive(4'd3, 1'b1, 1'b0, junk_op());
    drive(4'd4, 1'b1, 1'b0, junk_op());
    exp_instret++;
    drive(4'd0, 1'b1, 1'b0, junk_op());
    drive(4'd1, 1'b1, 1'b0, OP_SW);
    drive(4'd2, 1'b1, 1'b0, junk_op());
    drive(4'd5, 1'b0, 1'b0, junk_op());
    drive(4'd5, 1'b0, 1'b0, junk_op());
    #4;
    checks++;
    if (instret !== exp_instret || memwrite !== 1'b1)
      $display("FAIL sw_stall instret=%h memwrite=%b expected %h/1",
               instret, memwrite, exp_instret);
    else passes++;
    drive(4'd5, 1'b1, 1'b0, junk_op());
    exp_instret++;
    @(posedge clk); #2;
    checks++;
    if (instret !== exp_instret)
      $display("FAIL mem_stall_instret got %h expected %h", instret, exp_instret);
    else passes++;
  endtask

  task automatic test_trap();
    drive(4'd0, 1'b1, 1'b0, junk_op());
    drive(4'd1, 1'b1, 1'b0, OP_BAD);
    drive(4'd9, 1'b1, 1'b0, OP_LW);
    #4;
    checks++;
    if (illegal !== 1'b1 || instret !== exp_instret)
      $display("FAIL trap_enter illegal=%b instret=%h expected 1/%h",
               illegal, instret, exp_instret);
    else passes++;
    drive(4'd9, 1'b1, 1'b0, OP_LW);
    drive(4'd9, 1'b1, 1'b1, OP_LW);     // reset releases TRAP
    exp_instret = 16'd0;
  endtask

  task automatic test_reset_in_stall();
    drive(4'd0, 1'b1, 1'b1, junk_op());
    for (int i = 0; i < 5; i++) begin
      drive(4'd0, 1'b1, 1'b0, junk_op());
      drive(4'd1, 1'b1, 1'b0, OP_BEQ);
      drive(4'd8, 1'b1, 1'b0, junk_op());
      exp_instret++;
    end
    drive(4'd0, 1'b1, 1'b0, junk_op());
    drive(4'd1, 1'b1, 1'b0, OP_LW);
    drive(4'd2, 1'b1, 1'b0, junk_op());
    drive(4'd3, 1'b0, 1'b0, junk_op());
    #4;
    checks++;
    if (instret !== 16'd5)
      $display("FAIL stall_pre_reset instret=%h expected 0005", instret);
    else passes++;
    drive(4'd3, 1'b0, 1'b1, junk_op());
    drive(4'd0, 1'b0, 1'b0, junk_op());
    #4;
    checks++;
    if (instret !== 16'd0 || state !== 4'd0)
      $display("FAIL stall_reset instret=%h state=%0d expected 0000/0", instret, state);
    else passes++;
    exp_instret = 16'd0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1; mem_ready = 1'b0; opcode = 7'd0;
    test_reset();
    test_rt();
    test_lw_sw();
    test_beq();
    test_fetch_stall();
    test_mem_stall();
    test_trap();
    test_reset_in_stall();
    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0)
      $display("FAIL scoreboard_drain %0d entries left expected 0", exp_q.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
